// File: rtl/lw_sha256_padder.sv
// SHA-256 message padder: forwards 32-bit message words and appends the 0x80 marker,
// zero fill and 64-bit bit length, emitting whole 512-bit blocks through a single register stage.
module lw_sha256_padder #(
   parameter int LEN_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_last,
   input  logic [2:0]  s_nbytes,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_first,
   output logic        m_block_end,
   output logic        m_msg_end
);

   typedef enum logic [2:0] {MSG, PAD, ZERO, LEN_HI, LEN_LO} state_t;

   state_t           state_reg, state_next;
   logic [3:0]       wcnt_reg;
   logic [3:0]       load_idx;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [63:0]      len64;
   logic             m_valid_reg, m_valid_next;
   logic [31:0]      m_data_reg, m_data_next;
   logic             m_first_reg, m_first_next;
   logic             m_block_end_reg, m_block_end_next;
   logic             m_msg_end_reg, m_msg_end_next;
   logic             load_en, out_xfer;
   logic [2:0]       nb_eff;
   logic [31:0]      last_word;

   assign out_xfer = m_valid_reg && m_ready;
   assign load_en  = !m_valid_reg || m_ready;
   assign s_ready  = (state_reg == MSG) && load_en;

   // Index of the word that a load this cycle would place on m_data.
   assign load_idx = out_xfer ? wcnt_reg + 4'd1 : wcnt_reg;
   assign len64    = 64'(len_reg);
   assign nb_eff   = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;

   // Short last word: keep the leading valid bytes, place 0x80 right after them.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_last_byte
         assign last_word[31-8*gi -: 8] = (3'(gi) < nb_eff)  ? s_data[31-8*gi -: 8] :
                                          (3'(gi) == nb_eff) ? 8'h80 : 8'h00;
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      len_next         = len_reg;
      m_valid_next     = m_valid_reg;
      m_data_next      = m_data_reg;
      m_first_next     = m_first_reg;
      m_block_end_next = m_block_end_reg;
      m_msg_end_next   = m_msg_end_reg;
      if (load_en) begin
         m_valid_next     = 1'b1;
         m_first_next     = (load_idx == 4'd0);
         m_block_end_next = (load_idx == 4'd15);
         m_msg_end_next   = 1'b0;
         case (state_reg)
            MSG: begin
               m_valid_next = s_valid;
               if (!s_valid) begin
                  m_first_next     = 1'b0;
                  m_block_end_next = 1'b0;
               end else if (!s_last || nb_eff == 3'd4) begin
                  m_data_next = s_data;
                  len_next    = len_reg + LEN_W'(32);
                  if (s_last)
                     state_next = PAD;
               end else begin
                  m_data_next = last_word;
                  len_next    = len_reg + LEN_W'({nb_eff, 3'b000});
                  state_next  = (load_idx == 4'd13) ? LEN_HI : ZERO;
               end
            end
            PAD: begin
               m_data_next = 32'h8000_0000;
               state_next  = (load_idx == 4'd13) ? LEN_HI : ZERO;
            end
            ZERO: begin
               m_data_next = 32'h0000_0000;
               state_next  = (load_idx == 4'd13) ? LEN_HI : ZERO;
            end
            LEN_HI: begin
               m_data_next = len64[63:32];
               state_next  = LEN_LO;
            end
            LEN_LO: begin
               m_data_next    = len64[31:0];
               m_msg_end_next = 1'b1;
               len_next       = '0;
               state_next     = MSG;
            end
            default: state_next = MSG;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= MSG;
         wcnt_reg        <= 4'd0;
         len_reg         <= '0;
         m_valid_reg     <= 1'b0;
         m_data_reg      <= 32'h0;
         m_first_reg     <= 1'b0;
         m_block_end_reg <= 1'b0;
         m_msg_end_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         len_reg         <= len_next;
         m_valid_reg     <= m_valid_next;
         m_data_reg      <= m_data_next;
         m_first_reg     <= m_first_next;
         m_block_end_reg <= m_block_end_next;
         m_msg_end_reg   <= m_msg_end_next;
         if (out_xfer)
            wcnt_reg <= wcnt_reg + 4'd1;
      end
   end

   assign m_data      = m_data_reg;
   assign m_valid     = m_valid_reg;
   assign m_first     = m_first_reg;
   assign m_block_end = m_block_end_reg;
   assign m_msg_end   = m_msg_end_reg;

endmodule

// File: tb/tb_lw_sha256_padder.sv
// Directed bench for lw_sha256_padder: padded word streams, flags, backpressure hold
// and mid-message reset are checked against hand-derived padding expectations.
module tb_lw_sha256_padder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_last;
   logic [2:0]  s_nbytes;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        m_first;
   logic        m_block_end;
   logic        m_msg_end;

   int vectors = 0;
   int miscompares = 0;
   logic rand_mode = 1'b0;

   logic [34:0] out_q[$];
   logic [31:0] head[16];
   int          head_n;

   logic        hold_pend = 1'b0;
   logic [34:0] hold_word;

   lw_sha256_padder #(.LEN_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_last(s_last), .s_nbytes(s_nbytes),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_first(m_first), .m_block_end(m_block_end), .m_msg_end(m_msg_end)
   );

   always #5 clk = ~clk;

   // m_ready changes just after each rising edge, so it is stable at the falling edge.
   always begin
      @(posedge clk);
      #1;
      m_ready <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: a word seen with valid&ready at the falling edge transfers at the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend <= 1'b0;
      end else begin
         if (hold_pend)
            chk("hold", 64'({m_data, m_first, m_block_end, m_msg_end}), 64'(hold_word));
         hold_pend <= m_valid && !m_ready;
         hold_word <= {m_data, m_first, m_block_end, m_msg_end};
         if (m_valid && m_ready)
            out_q.push_back({m_data, m_first, m_block_end, m_msg_end});
      end
   end

   // Called at a falling edge; returns at the falling edge after the word was accepted.
   task automatic send(input logic [31:0] d, input logic l, input logic [2:0] n);
      int k;
      logic acc;
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = l;
      s_nbytes = n;
      k = 0;
      acc = 1'b0;
      while (!acc && k < 200) begin
         acc = s_ready;
         @(negedge clk);
         k++;
      end
      if (!acc) chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic idle();
      s_valid  = 1'b0;
      s_last   = 1'b0;
      s_nbytes = 3'd0;
      s_data   = 32'hDEAD_BEEF;
   endtask

   // Expected stream: head words, zero fill, 64-bit length in the last two words.
   task automatic expect_msg(input string tag, input int nblocks, input logic [63:0] bitlen);
      int total, k;
      logic [31:0] ed;
      logic [34:0] got;
      total = nblocks * 16;
      k = 0;
      while (out_q.size() < total && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (out_q.size() < total) begin
         chk({tag, "_timeout"}, 64'(out_q.size()), 64'(total));
      end else begin
         for (int i = 0; i < total; i++) begin
            if (i < head_n)             ed = head[i];
            else if (i == total - 2)    ed = bitlen[63:32];
            else if (i == total - 1)    ed = bitlen[31:0];
            else                        ed = 32'h0;
            got = out_q.pop_front();
            chk($sformatf("%s[%0d]", tag, i), 64'(got),
                64'({ed, (i % 16 == 0), (i % 16 == 15), (i == total - 1)}));
         end
         repeat (4) @(negedge clk);
         chk({tag, "_extra"}, 64'(out_q.size()), 64'(0));
      end
      out_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_data", 64'(m_data), 64'(0));
      chk("rst_flags", 64'({m_first, m_block_end, m_msg_end}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'(1));
      chk("rst_idle_valid", 64'(m_valid), 64'(0));

      // "abc"
      send(32'h6162_6300, 1'b1, 3'd3);
      idle();
      head[0] = 32'h6162_6380; head_n = 1;
      expect_msg("abc", 1, 64'd24);
      $display("abc done");

      // empty message
      send(32'h1234_5678, 1'b1, 3'd0);
      idle();
      head[0] = 32'h8000_0000; head_n = 1;
      expect_msg("empty", 1, 64'd0);
      $display("empty done");

      // 2-byte message "hi"
      send(32'h6869_AAAA, 1'b1, 3'd2);
      idle();
      head[0] = 32'h6869_8000; head_n = 1;
      expect_msg("two_byte", 1, 64'd16);
      $display("two_byte done");

      // 5-byte message: one full word plus one byte
      send(32'h1122_3344, 1'b0, 3'd0);
      send(32'h55AA_BBCC, 1'b1, 3'd1);
      idle();
      head[0] = 32'h1122_3344; head[1] = 32'h5580_0000; head_n = 2;
      expect_msg("five_byte", 1, 64'd40);
      $display("five_byte done");

      // 56 bytes: full last word at 13, marker at 14, extra block
      for (int i = 0; i < 14; i++) begin
         send(32'h0102_0304 + 32'(i), (i == 13), 3'd4);
         head[i] = 32'h0102_0304 + 32'(i);
      end
      idle();
      head[14] = 32'h8000_0000; head_n = 15;
      expect_msg("b56", 2, 64'h1C0);
      $display("b56 done");

      // 55 bytes: short last word lands at 13, single block
      for (int i = 0; i < 13; i++) begin
         send(32'hA000_0000 + 32'(i), 1'b0, 3'd0);
         head[i] = 32'hA000_0000 + 32'(i);
      end
      send(32'hAABB_CCDD, 1'b1, 3'd3);
      idle();
      head[13] = 32'hAABB_CC80; head_n = 14;
      expect_msg("b55", 1, 64'h1B8);
      $display("b55 done");

      // "abc" under random backpressure
      rand_mode = 1'b1;
      send(32'h6162_6300, 1'b1, 3'd3);
      idle();
      head[0] = 32'h6162_6380; head_n = 1;
      expect_msg("abc_bp", 1, 64'd24);
      rand_mode = 1'b0;
      @(negedge clk);
      $display("abc_bp done");

      // reset at word 5 of a 20-word message, then "abc"
      for (int i = 0; i < 5; i++)
         send(32'hC000_0000 + 32'(i), 1'b0, 3'd0);
      s_data = 32'hC000_0005;
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      out_q.delete();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_valid[%0d]", i), 64'(m_valid), 64'(0));
      end
      send(32'h6162_6300, 1'b1, 3'd3);
      idle();
      head[0] = 32'h6162_6380; head_n = 1;
      expect_msg("abc_after_rst", 1, 64'd24);
      $display("abc_after_rst done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lw_sha256_padder.md
LW_SHA256_PADDER -- requirements
Module: lw_sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 64, giving the message-bit-length counter width (SHA-256 length field).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_data  input  32  message word, big-endian: byte 0 in [31:24].
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_ready  output  1  padder accepts s_data this cycle.
REQ-007 SHALL have port s_last  input  1  final word of the message.
REQ-008 SHALL have port s_nbytes  input  3  valid bytes (0..4, MSB-first) in a last word; ignored when s_last=0; 0 permits an empty message.
REQ-009 SHALL have port m_data  output  32  padded block word, to the SHA round core.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-012 SHALL have port m_first  output  1  m_data is word 0 of a 512-bit block.
REQ-013 SHALL have port m_block_end  output  1  m_data is word 15 of a block.
REQ-014 SHALL have port m_msg_end  output  1  m_data is word 15 of the final block of the message.

Function
REQ-015 Handshake: a transfer occurs on each channel when valid and ready are both high at a clock edge. Once m_valid is high, m_data and all m_* flags SHALL be held stable until m_ready.
REQ-016 Output SHALL be one registered stage. An accepted s_data appears on m_data the next cycle. s_ready = (state==MSG) && (!m_valid || m_ready).
REQ-017 Word counter wcnt (4 bits, 0..15) SHALL advance on every output transfer and wrap 15->0. m_first = (wcnt==0); m_block_end = (wcnt==15).
REQ-018 Length counter len (LEN_W bits) SHALL add 32 per accepted non-last word and 8*s_nbytes for the last word. It wraps modulo 2^LEN_W, and clears after LEN_LO transfers.
REQ-019 FSM states SHALL be MSG, PAD, ZERO, LEN_HI and LEN_LO, with output words as follows:
- MSG: forwards words.
- PAD: emits 0x80000000.
- ZERO: emits 0x00000000.
- LEN_HI: emits len[63:32].
- LEN_LO: emits len[31:0].
REQ-020 Last word with s_nbytes=n<4 SHALL be emitted as bytes 0..n-1 of s_data, then byte 0x80 at byte position n, then zero bytes. The next state SHALL be ZERO, or LEN_HI if that word lands at wcnt==13.
REQ-021 Last word with s_nbytes=4 SHALL be forwarded unchanged, and the next state SHALL be PAD.
REQ-022 After the 0x80-bearing word, the padder SHALL emit zeros until wcnt==14, then LEN_HI at word 14 and LEN_LO at word 15.
REQ-023 If the 0x80-bearing word lands at wcnt 14 or 15, the padder SHALL zero-fill to word 15 (m_block_end=1, m_msg_end=0). It SHALL then emit a full extra block: 14 zeros plus the length.
REQ-024 m_msg_end SHALL be high only on the LEN_LO word. After that word transfers, the state SHALL return to MSG with wcnt=0.
REQ-025 s_valid with s_ready=0 SHALL not be consumed. s_data is don't-care when s_valid=0.
REQ-026 Input/output transfers in the same cycle (back-to-back streaming) SHALL sustain 1 word/cycle in MSG.

Reset
REQ-027 While rst_n=0, all state SHALL clear asynchronously: state=MSG, wcnt=0, len=0, m_valid=0, m_data=0, m_first/m_block_end/m_msg_end=0.
REQ-028 s_ready SHALL be 1 after reset.
REQ-029 Reset asserted mid-message or mid-padding SHALL abandon the message with no further m_valid. The first message after release SHALL be padded as if none preceded it.

Verification
REQ-030 "abc": s_data=0x61626300, s_last=1, s_nbytes=3. Required output:
- word 0 = 0x61626380 (m_first);
- words 1..14 = 0;
- word 15 = 0x00000018 with m_block_end=1 and m_msg_end=1.
REQ-031 Empty message: s_last=1, s_nbytes=0. Required output: word 0 = 0x80000000, words 1..15 = 0, m_msg_end on word 15.
REQ-032 56-byte message, 14 full words, last with s_nbytes=4. Required output:
- block 1: word 14 = 0x80000000, word 15 = 0 (m_block_end=1, m_msg_end=0);
- block 2: words 0..13 = 0, word 14 = 0, word 15 = 0x000001C0.
REQ-033 55-byte message, last word s_nbytes=3 at word 13. Required output: word 13 = data|0x80, word 14 = 0, word 15 = 0x000001B8, single block.
REQ-034 Backpressure: drive m_ready with a random 50% pattern during "abc". m_data/flags SHALL be held while stalled, and the 16-word sequence SHALL be identical to REQ-030.
REQ-035 Pull rst_n low at word 5 of a 20-word message, then send "abc". The output SHALL match REQ-030 exactly.
